// File: rtl/sat_mac_pipe.sv
// sat_mac_pipe
//   Two-stage signed saturating multiplier / multiply-accumulator with
//   valid/ready flow control and optional Q-format output scaling.
//   S1 registers the full-width product; S2 scales (round half up),
//   saturates, optionally accumulates, and drives the output beat.
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   valid_in / ready_o      input handshake
//   a_in, b_in              signed operands (DATA_WIDTH)
//   mode_in                 0 = multiply, 1 = multiply-accumulate
//   first_in                mode 1: start a new sum from zero
//   valid_o / ready_in      output handshake
//   res_o                   signed saturated result
//   sat_o                   saturation occurred while producing this beat
module sat_mac_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 0
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         valid_in,
    output logic                         ready_o,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic signed [DATA_WIDTH-1:0] b_in,
    input  logic                         mode_in,
    input  logic                         first_in,
    output logic                         valid_o,
    input  logic                         ready_in,
    output logic signed [DATA_WIDTH-1:0] res_o,
    output logic                         sat_o
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;

    // Output range limits, both at result width and at scaled-product width
    localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [PW:0]   QMAX = {{(PW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW:0]   QMIN = {{(PW-DW+2){1'b1}}, {(DW-1){1'b0}}};

    // Stage 1
    logic                 r_s1_valid;
    logic signed [PW-1:0] r_s1_prod;
    logic                 r_s1_mode;
    logic                 r_s1_first;

    // Stage 2 / output
    logic                 r_valid;
    logic signed [DW-1:0] r_res;
    logic                 r_sat;
    logic signed [DW-1:0] r_acc;

    logic                 w_adv1;
    logic                 w_adv2;
    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW:0]   w_p_ext;
    logic signed [PW:0]   w_q;
    logic signed [DW-1:0] w_qs;
    logic                 w_sat_m;
    logic signed [DW-1:0] w_base;
    logic        [DW:0]   w_sum;
    logic                 w_sum_clip;
    logic signed [DW-1:0] w_sums;
    logic signed [DW-1:0] w_res;
    logic                 w_sat;

    assign w_adv2  = !r_valid || ready_in;
    assign w_adv1  = !r_s1_valid || w_adv2;
    assign ready_o = w_adv1;

    assign valid_o = r_valid;
    assign res_o   = r_res;
    assign sat_o   = r_sat;

    // Operands widened so the multiply is evaluated at full product width
    assign w_a_ext = {{DW{a_in[DW-1]}}, a_in};
    assign w_b_ext = {{DW{b_in[DW-1]}}, b_in};

    // One guard bit so the rounding add can never wrap
    assign w_p_ext = {r_s1_prod[PW-1], r_s1_prod};

    generate
        if (FRAC_BITS > 0) begin : g_scale
            localparam logic signed [PW:0] RND = {{PW{1'b0}}, 1'b1} << (FRAC_BITS - 1);
            assign w_q = (w_p_ext + RND) >>> FRAC_BITS;
        end else begin : g_noscale
            assign w_q = w_p_ext;
        end
    endgenerate

    always_comb begin
        w_qs    = w_q[DW-1:0];
        w_sat_m = 1'b0;
        if (w_q > QMAX) begin
            w_qs    = MAXV;
            w_sat_m = 1'b1;
        end else if (w_q < QMIN) begin
            w_qs    = MINV;
            w_sat_m = 1'b1;
        end
    end

    // Accumulate in DW+1 bits; overflow shows as the top two bits disagreeing
    assign w_base     = r_s1_first ? '0 : r_acc;
    assign w_sum      = {w_base[DW-1], w_base} + {w_qs[DW-1], w_qs};
    assign w_sum_clip = w_sum[DW] ^ w_sum[DW-1];
    assign w_sums     = w_sum_clip ? (w_sum[DW] ? MINV : MAXV) : $signed(w_sum[DW-1:0]);

    assign w_res = r_s1_mode ? w_sums : w_qs;
    assign w_sat = w_sat_m | (r_s1_mode & w_sum_clip);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_first <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_prod  <= w_a_ext * w_b_ext;
                r_s1_mode  <= mode_in;
                r_s1_first <= first_in;
            end
        end
    end

    // Accumulator only moves with a beat entering S2, so stalls never double-count
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_valid <= 1'b0;
            r_res   <= '0;
            r_sat   <= 1'b0;
            r_acc   <= '0;
        end else if (w_adv2) begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res <= w_res;
                r_sat <= w_sat;
                if (r_s1_mode) r_acc <= w_sums;
            end
        end
    end

endmodule

// File: tb/tb_sat_mac_pipe.sv
// Bench for sat_mac_pipe: instance A with FRAC_BITS=0, instance B with
// FRAC_BITS=15. Stimulus pushes expected beats into per-instance queues;
// monitors pop and compare on each output transfer.
module tb_sat_mac_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        va, ra_o, ma, fa, vao, rai, sa;
    logic [15:0] aa, ba, resa;
    logic        vb, rb_o, mb, fb, vbo, rbi, sb;
    logic [15:0] ab, bb, resb;

    sat_mac_pipe #(.DATA_WIDTH(16), .FRAC_BITS(0)) u_a (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(va), .ready_o(ra_o),
        .a_in(aa), .b_in(ba), .mode_in(ma), .first_in(fa),
        .valid_o(vao), .ready_in(rai), .res_o(resa), .sat_o(sa));

    sat_mac_pipe #(.DATA_WIDTH(16), .FRAC_BITS(15)) u_b (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(vb), .ready_o(rb_o),
        .a_in(ab), .b_in(bb), .mode_in(mb), .first_in(fb),
        .valid_o(vbo), .ready_in(rbi), .res_o(resb), .sat_o(sb));

    typedef struct {
        logic [15:0] res;
        logic        sat;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    // Monitor A: in-order compare, latency check, hold-stable check during stalls
    logic        hold_v;
    logic [15:0] hold_res;
    logic        hold_sat;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v) begin
                chk("a_hold_valid", {31'd0, vao}, 32'd1);
                chk("a_hold_res", {16'd0, resa}, {16'd0, hold_res});
                chk("a_hold_sat", {31'd0, sa}, {31'd0, hold_sat});
            end
            if (vao && rai) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    chk("a_res", {16'd0, resa}, {16'd0, e.res});
                    chk("a_sat", {31'd0, sa}, {31'd0, e.sat});
                    if (e.lat) chk("a_latency", cyc - e.cyc, 32'd2);
                end
            end
            hold_v   <= vao && !rai;
            hold_res <= resa;
            hold_sat <= sa;
        end
    end

    // Monitor B
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && vbo && rbi) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_res", {16'd0, resb}, {16'd0, e.res});
                chk("b_sat", {31'd0, sb}, {31'd0, e.sat});
                if (e.lat) chk("b_latency", cyc - e.cyc, 32'd2);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted
    task automatic send(input bit sel, input logic [15:0] a, input logic [15:0] b,
                        input logic m, input logic f,
                        input logic [15:0] er, input logic es, input bit lat);
        int n = 0;
        exp_t e;
        if (sel) begin vb = 1'b1; ab = a; bb = b; mb = m; fb = f; end
        else     begin va = 1'b1; aa = a; ba = b; ma = m; fa = f; end
        @(negedge clk);
        while (!(sel ? rb_o : ra_o) && n < 50) begin n++; @(negedge clk); end
        if (!(sel ? rb_o : ra_o)) begin
            chk("send_timeout", 32'd1, 32'd0);
        end else begin
            e.res = er; e.sat = es; e.cyc = cyc; e.lat = lat;
            if (sel) qb.push_back(e); else qa.push_back(e);
        end
        @(posedge clk); #1;
        if (sel) vb = 1'b0; else va = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            n++; @(posedge clk); #1;
        end
        if (qa.size() != 0 || qb.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        va = 0; aa = 0; ba = 0; ma = 0; fa = 0; rai = 1;
        vb = 0; ab = 0; bb = 0; mb = 0; fb = 0; rbi = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_o", {31'd0, vao}, 32'd0);
        chk("rst_res_o", {16'd0, resa}, 32'd0);
        chk("rst_sat_o", {31'd0, sa}, 32'd0);
        chk("rst_ready_o", {31'd0, ra_o}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiply, FRAC=0
        send(0, 16'd100,   16'hFFFD, 0, 0, 16'hFED4, 0, 1);
        send(0, 16'd300,   16'd200,  0, 0, 16'h7FFF, 1, 1);
        send(0, 16'hFED4,  16'd200,  0, 0, 16'h8000, 1, 1);
        send(0, 16'h8000,  16'h8000, 0, 0, 16'h7FFF, 1, 1);
        // MAC run to saturation, restart, multiply leaves acc alone
        send(0, 16'd1000,  16'd10,   1, 1, 16'd10000, 0, 1);
        send(0, 16'd1000,  16'd10,   1, 0, 16'd20000, 0, 1);
        send(0, 16'd1000,  16'd10,   1, 0, 16'd30000, 0, 1);
        send(0, 16'd2000,  16'd10,   1, 0, 16'h7FFF,  1, 1);
        send(0, 16'd5,     16'd5,    1, 1, 16'd25,    0, 1);
        send(0, 16'd2,     16'd3,    0, 0, 16'd6,     0, 1);
        send(0, 16'd1,     16'd1,    1, 0, 16'd26,    0, 1);
        drain();

        // Back-to-back, 8 beats
        for (int i = 1; i <= 8; i++)
            send(0, 16'(i), 16'd7, 0, 0, 16'(i * 7), 0, 1);
        drain();

        // Downstream stall
        rai = 1'b0;
        send(0, 16'd2, 16'd2, 0, 0, 16'd4, 0, 0);
        send(0, 16'd3, 16'd3, 0, 0, 16'd9, 0, 0);
        va = 1'b1; aa = 16'd4; ba = 16'd4; ma = 0; fa = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready_low", {31'd0, ra_o}, 32'd0);
        end
        @(posedge clk); #1;
        rai = 1'b1;
        send(0, 16'd4, 16'd4, 0, 0, 16'd16, 0, 0);
        drain();

        // Reset mid MAC stream
        send(0, 16'd3, 16'd3, 1, 1, 16'd9,  0, 0);
        send(0, 16'd3, 16'd3, 1, 0, 16'd18, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_o", {31'd0, vao}, 32'd0);
        qa.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_idle", {31'd0, vao}, 32'd0);
        end
        @(posedge clk); #1;
        send(0, 16'd3, 16'd3, 1, 0, 16'd9, 0, 1);
        drain();

        // FRAC=15 scaling with round half up
        send(1, 16'h4000, 16'h4000, 0, 0, 16'h2000, 0, 1);
        send(1, 16'h0001, 16'h4000, 0, 0, 16'h0001, 0, 1);
        send(1, 16'h0001, 16'h0001, 0, 0, 16'h0000, 0, 1);
        send(1, 16'hFFFF, 16'h4000, 0, 0, 16'h0000, 0, 1);
        send(1, 16'h8000, 16'h8000, 0, 0, 16'h7FFF, 1, 1);
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
